// File: rtl/alu_exec_if.sv
// Handshake and data bundle between the ALU control/operand source and the
// EX/MEM output register of the execute stage.
interface alu_exec_if #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [RD_W-1:0] rd_in;
  logic            reg_write_in;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [RD_W-1:0] rd_out;
  logic            reg_write_out;
  logic            illegal_op;
  logic [31:0]     op_count;

  modport master (
    output in_valid, alu_control, op_a, op_b, rd_in, reg_write_in, flush, out_ready,
    input  in_ready, out_valid, result, zero, rd_out, reg_write_out, illegal_op, op_count
  );

  modport slave (
    input  in_valid, alu_control, op_a, op_b, rd_in, reg_write_in, flush, out_ready,
    output in_ready, out_valid, result, zero, rd_out, reg_write_out, illegal_op, op_count
  );
endinterface

// File: rtl/alu_exec_stage.sv
// RV64 execute stage: combinational ALU feeding a single-entry EX/MEM register
// with valid/ready handshake, flush, illegal-code flagging and an op counter.
module alu_exec_stage #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_exec_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] alu_res_s;
  logic            illegal_s;
  logic [SHW-1:0]  shamt_s;
  logic            in_ready_s;
  logic            accept_s;

  logic            out_valid_r;
  logic [XLEN-1:0] result_r;
  logic            zero_r;
  logic [RD_W-1:0] rd_r;
  logic            reg_write_r;
  logic            illegal_r;
  logic [31:0]     op_count_r;

  // Ready only depends on flush and the output register occupancy, never on in_valid.
  assign in_ready_s = !bus.flush && (!out_valid_r || bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign shamt_s    = bus.op_b[SHW-1:0];

  // ALU datapath; unknown control codes produce a zero result and raise illegal.
  always_comb begin
    alu_res_s = {XLEN{1'b0}};
    illegal_s = 1'b0;
    case (bus.alu_control)
      4'b0000: alu_res_s = bus.op_a & bus.op_b;
      4'b0001: alu_res_s = bus.op_a | bus.op_b;
      4'b0010: alu_res_s = bus.op_a + bus.op_b;
      4'b0110: alu_res_s = bus.op_a - bus.op_b;
      4'b0111: alu_res_s = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      4'b1000: alu_res_s = bus.op_a ^ bus.op_b;
      4'b1001: alu_res_s = bus.op_a << shamt_s;
      4'b1010: alu_res_s = bus.op_a >> shamt_s;
      4'b1011: alu_res_s = $unsigned($signed(bus.op_a) >>> shamt_s);
      4'b1100: alu_res_s = {{(XLEN-1){1'b0}}, (bus.op_a < bus.op_b)};
      default: begin
        alu_res_s = {XLEN{1'b0}};
        illegal_s = 1'b1;
      end
    endcase
  end

  // EX/MEM register: flush wins, then accept (covers back-to-back), then drain, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      result_r    <= {XLEN{1'b0}};
      zero_r      <= 1'b0;
      rd_r        <= {RD_W{1'b0}};
      reg_write_r <= 1'b0;
      illegal_r   <= 1'b0;
      op_count_r  <= 32'd0;
    end else if (bus.flush) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      result_r    <= alu_res_s;
      zero_r      <= (alu_res_s == {XLEN{1'b0}});
      rd_r        <= bus.rd_in;
      reg_write_r <= bus.reg_write_in && !illegal_s;
      illegal_r   <= illegal_s;
      op_count_r  <= op_count_r + 32'd1;
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready      = in_ready_s;
  assign bus.out_valid     = out_valid_r;
  assign bus.result        = result_r;
  assign bus.zero          = zero_r;
  assign bus.rd_out        = rd_r;
  assign bus.reg_write_out = reg_write_r;
  assign bus.illegal_op    = illegal_r;
  assign bus.op_count      = op_count_r;
endmodule
